// File: rtl/spart_fifo.sv
// spart_fifo: UART with a 16x-oversampled baud generator, TX/RX FIFOs
// and sticky error flags, attached to a 2-bit-address processor I/O bus.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   iocs, iorw    chip select, 1 = read / 0 = write
//   ioaddr[1:0]   00 data, 01 status, 10 divisor low, 11 divisor high
//   databus[7:0]  bidirectional, driven only while iocs=1 and iorw=1
//   rda, tbr      RX FIFO not empty, TX FIFO not full
//   txd, rxd      serial transmit (idle high), asynchronous receive
//
// Optional macro SPART_PARITY_EN: even parity bit after the data bits,
// enabled by writing bit 0 of address 01.
module spart_fifo #(
    parameter int          DATA_W   = 8,
    parameter int          TX_DEPTH = 4,
    parameter int          RX_DEPTH = 4,
    parameter logic [15:0] DIV_RST  = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    localparam int         TAW  = $clog2(TX_DEPTH);
    localparam int         RAW  = $clog2(RX_DEPTH);
    localparam logic [2:0] LAST = 3'(DATA_W - 1);
    localparam logic [TAW:0] TONE = 1;
    localparam logic [RAW:0] RONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    logic w_rd, w_wr;
    logic w_wr_data, w_wr_lo, w_wr_hi, w_rd_stat;
    assign w_rd      = iocs && iorw;
    assign w_wr      = iocs && !iorw;
    assign w_wr_data = w_wr && (ioaddr == 2'b00);
    assign w_wr_lo   = w_wr && (ioaddr == 2'b10);
    assign w_wr_hi   = w_wr && (ioaddr == 2'b11);
    assign w_rd_stat = w_rd && (ioaddr == 2'b01);

    logic w_par_on;
`ifdef SPART_PARITY_EN
    logic r_par_en;
    always_ff @(posedge clk) begin
        if (rst) r_par_en <= 1'b0;
        else if (w_wr && (ioaddr == 2'b01)) r_par_en <= databus[0];
    end
    assign w_par_on = r_par_en;
`else
    assign w_par_on = 1'b0;
`endif

    // Baud generator: a divisor write restarts the count immediately.
    logic [15:0] r_div, r_cnt;
    logic        w_tick;
    assign w_tick = (r_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DIV_RST;
            r_cnt <= DIV_RST;
        end else if (w_wr_lo) begin
            r_div <= {r_div[15:8], databus};
            r_cnt <= {r_div[15:8], databus};
        end else if (w_wr_hi) begin
            r_div <= {databus, r_div[7:0]};
            r_cnt <= {databus, r_div[7:0]};
        end else if (w_tick) begin
            r_cnt <= r_div;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // TX FIFO; pointers carry a wrap bit to tell full from empty.
    logic [DATA_W-1:0] r_txf [TX_DEPTH];
    logic [TAW:0]      r_txf_wp, r_txf_rp;
    logic              w_txf_empty, w_txf_full, w_txf_push, w_tx_pop;
    logic [DATA_W-1:0] w_txf_head;
    assign w_txf_empty = (r_txf_wp == r_txf_rp);
    assign w_txf_full  = (r_txf_wp[TAW] != r_txf_rp[TAW]) &&
                         (r_txf_wp[TAW-1:0] == r_txf_rp[TAW-1:0]);
    assign w_txf_head  = r_txf[r_txf_rp[TAW-1:0]];
    assign w_txf_push  = w_wr_data && (!w_txf_full || w_tx_pop);
    assign tbr         = !w_txf_full;

    always_ff @(posedge clk) begin
        if (w_txf_push) r_txf[r_txf_wp[TAW-1:0]] <= databus[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txf_wp <= '0;
            r_txf_rp <= '0;
        end else begin
            if (w_txf_push) r_txf_wp <= r_txf_wp + TONE;
            if (w_tx_pop)   r_txf_rp <= r_txf_rp + TONE;
        end
    end

    // TX FSM
    state_t            r_tx_st, w_tx_st_n;
    logic [3:0]        r_tx_tc, w_tx_tc_n;
    logic [2:0]        r_tx_bc, w_tx_bc_n;
    logic [DATA_W-1:0] r_tx_sh, w_tx_sh_n;
    logic              w_tx_load, w_tx_end, w_tx_pbit, w_tx_idle;
    assign w_tx_end  = (r_tx_tc == 4'd15);
    assign w_tx_idle = (r_tx_st == S_IDLE) && w_txf_empty;

`ifdef SPART_PARITY_EN
    logic r_tx_par;
    always_ff @(posedge clk) begin
        if (rst) r_tx_par <= 1'b0;
        else if (w_tx_load) r_tx_par <= ^w_txf_head;
    end
    assign w_tx_pbit = r_tx_par;
`else
    assign w_tx_pbit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st <= S_IDLE;
            r_tx_tc <= 4'd0;
            r_tx_bc <= 3'd0;
            r_tx_sh <= '0;
        end else begin
            r_tx_st <= w_tx_st_n;
            r_tx_tc <= w_tx_tc_n;
            r_tx_bc <= w_tx_bc_n;
            r_tx_sh <= w_tx_sh_n;
        end
    end

    always_comb begin
        w_tx_st_n = r_tx_st;
        w_tx_tc_n = r_tx_tc;
        w_tx_bc_n = r_tx_bc;
        w_tx_sh_n = r_tx_sh;
        w_tx_load = 1'b0;
        w_tx_pop  = 1'b0;
        unique case (r_tx_st)
            S_START: txd = 1'b0;
            S_DATA:  txd = r_tx_sh[0];
            S_PAR:   txd = w_tx_pbit;
            default: txd = 1'b1;
        endcase
        if (w_tick) begin
            w_tx_tc_n = r_tx_tc + 4'd1;
            unique case (r_tx_st)
                S_IDLE: begin
                    w_tx_tc_n = 4'd0;
                    w_tx_load = !w_txf_empty;
                end
                S_START: if (w_tx_end) begin
                    w_tx_st_n = S_DATA;
                    w_tx_bc_n = 3'd0;
                end
                S_DATA: if (w_tx_end) begin
                    w_tx_sh_n = r_tx_sh >> 1;
                    if (r_tx_bc == LAST)
                        w_tx_st_n = w_par_on ? S_PAR : S_STOP;
                    else
                        w_tx_bc_n = r_tx_bc + 3'd1;
                end
                S_PAR: if (w_tx_end) w_tx_st_n = S_STOP;
                S_STOP: if (w_tx_end) begin
                    if (!w_txf_empty) w_tx_load = 1'b1;
                    else w_tx_st_n = S_IDLE;
                end
                default: w_tx_st_n = S_IDLE;
            endcase
            // STOP with data waiting chains straight into the next START.
            if (w_tx_load) begin
                w_tx_pop  = 1'b1;
                w_tx_sh_n = w_txf_head;
                w_tx_tc_n = 4'd0;
                w_tx_st_n = S_START;
            end
        end
    end

    // RX synchroniser; r_rx_last holds the line at the previous tick.
    logic r_rx_s1, r_rx_s2, r_rx_last;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_last <= 1'b1;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            if (w_tick) r_rx_last <= r_rx_s2;
        end
    end

    // RX FIFO
    logic [DATA_W-1:0] r_rxf [RX_DEPTH];
    logic [RAW:0]      r_rxf_wp, r_rxf_rp;
    logic              w_rxf_empty, w_rxf_full, w_rxf_push, w_rxf_pop;
    logic [DATA_W-1:0] w_rxf_head;
    assign w_rxf_empty = (r_rxf_wp == r_rxf_rp);
    assign w_rxf_full  = (r_rxf_wp[RAW] != r_rxf_rp[RAW]) &&
                         (r_rxf_wp[RAW-1:0] == r_rxf_rp[RAW-1:0]);
    assign w_rxf_head  = r_rxf[r_rxf_rp[RAW-1:0]];
    assign w_rxf_pop   = w_rd && (ioaddr == 2'b00) && !w_rxf_empty;
    assign rda         = !w_rxf_empty;

    // RX FSM
    state_t            r_rx_st, w_rx_st_n;
    logic [3:0]        r_rx_tc, w_rx_tc_n;
    logic [2:0]        r_rx_bc, w_rx_bc_n;
    logic [DATA_W-1:0] r_rx_sh, w_rx_sh_n;
    logic              w_rx_done, w_rx_end;
    assign w_rx_end = (r_rx_tc == 4'd15);

    logic w_rx_ok, w_rx_ferr, w_rx_ovr, w_rx_perr;
    assign w_rx_ok    = w_rx_done && r_rx_s2;
    assign w_rx_ferr  = w_rx_done && !r_rx_s2;
    assign w_rx_ovr   = w_rx_ok && w_rxf_full && !w_rxf_pop;
    assign w_rxf_push = w_rx_ok && (!w_rxf_full || w_rxf_pop);

`ifdef SPART_PARITY_EN
    logic r_rx_pb, w_rx_pb_n;
    always_ff @(posedge clk) begin
        if (rst) r_rx_pb <= 1'b0;
        else r_rx_pb <= w_rx_pb_n;
    end
    assign w_rx_perr = w_rx_ok && r_par_en && (^{r_rx_sh, r_rx_pb});
`else
    assign w_rx_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_rxf_push) r_rxf[r_rxf_wp[RAW-1:0]] <= r_rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxf_wp <= '0;
            r_rxf_rp <= '0;
        end else begin
            if (w_rxf_push) r_rxf_wp <= r_rxf_wp + RONE;
            if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + RONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_st <= S_IDLE;
            r_rx_tc <= 4'd0;
            r_rx_bc <= 3'd0;
            r_rx_sh <= '0;
        end else begin
            r_rx_st <= w_rx_st_n;
            r_rx_tc <= w_rx_tc_n;
            r_rx_bc <= w_rx_bc_n;
            r_rx_sh <= w_rx_sh_n;
        end
    end

    always_comb begin
        w_rx_st_n = r_rx_st;
        w_rx_tc_n = r_rx_tc;
        w_rx_bc_n = r_rx_bc;
        w_rx_sh_n = r_rx_sh;
        w_rx_done = 1'b0;
`ifdef SPART_PARITY_EN
        w_rx_pb_n = r_rx_pb;
`endif
        if (w_tick) begin
            w_rx_tc_n = r_rx_tc + 4'd1;
            unique case (r_rx_st)
                S_IDLE: begin
                    w_rx_tc_n = 4'd0;
                    if (r_rx_last && !r_rx_s2) w_rx_st_n = S_START;
                end
                // Eight ticks after the edge is mid start bit.
                S_START: if (r_rx_tc == 4'd7) begin
                    w_rx_tc_n = 4'd0;
                    w_rx_bc_n = 3'd0;
                    w_rx_st_n = r_rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (w_rx_end) begin
                    w_rx_sh_n = {r_rx_s2, r_rx_sh[DATA_W-1:1]};
                    if (r_rx_bc == LAST)
                        w_rx_st_n = w_par_on ? S_PAR : S_STOP;
                    else
                        w_rx_bc_n = r_rx_bc + 3'd1;
                end
                S_PAR: if (w_rx_end) begin
`ifdef SPART_PARITY_EN
                    w_rx_pb_n = r_rx_s2;
`endif
                    w_rx_st_n = S_STOP;
                end
                S_STOP: if (w_rx_end) begin
                    w_rx_done = 1'b1;
                    w_rx_st_n = S_IDLE;
                end
                default: w_rx_st_n = S_IDLE;
            endcase
        end
    end

    // Sticky flags: a status read clears, a new event in that cycle wins.
    logic r_ovr, r_ferr, w_perr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= w_rx_ovr  || (r_ovr  && !w_rd_stat);
            r_ferr <= w_rx_ferr || (r_ferr && !w_rd_stat);
        end
    end

`ifdef SPART_PARITY_EN
    logic r_perr;
    always_ff @(posedge clk) begin
        if (rst) r_perr <= 1'b0;
        else r_perr <= w_rx_perr || (r_perr && !w_rd_stat);
    end
    assign w_perr = r_perr;
`else
    assign w_perr = w_rx_perr;
`endif

    logic [7:0] w_rdata;
    always_comb begin
        w_rdata = 8'h00;
        unique case (ioaddr)
            2'b00: if (!w_rxf_empty) w_rdata = 8'(w_rxf_head);
            2'b01: w_rdata = {2'b00, w_tx_idle, w_perr,
                              r_ferr, r_ovr, tbr, rda};
            2'b10: w_rdata = r_div[7:0];
            2'b11: w_rdata = r_div[15:8];
            default: w_rdata = 8'h00;
        endcase
    end

    assign databus = w_rd ? w_rdata : 8'hzz;

endmodule

// File: doc/spart_fifo.md
Name: spart_fifo

Overview:
- Parametrised successor to the single-buffer SPART: a UART with programmable 16x-oversampled baud generator, TX and RX FIFOs, a configurable data width and sticky error flags.
- Sits between the processor's 2-bit I/O bus (iocs/iorw/ioaddr/databus) and the board serial pins txd/rxd.
- Adds an oversampling receiver, which the previous generation lacks.

Parameters:
- DATA_W, 8, serial data bits per frame; legal range 5..8; bus data zero-extended to 8 bits.
- TX_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, at least 2.
- DIV_RST, 16'd325, divisor register reset value.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- iocs  in  1  chip select; bus access is ignored when 0.
- iorw  in  1  1 = read, 0 = write.
- ioaddr  in  2  register select.
- databus  inout  8  bidirectional data; driven only when iocs=1 and iorw=1, otherwise high-Z.
- rda  out  1  RX FIFO not empty.
- tbr  out  1  TX FIFO not full.
- txd  out  1  serial transmit; idle high.
- rxd  in  1  serial receive; asynchronous.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - txd=1, rda=0, tbr=1.
  - FIFOs empty, divisor=DIV_RST, baud counter=DIV_RST.
  - Error flags 0, TX and RX FSMs in IDLE.
- Reset asserted mid-frame aborts the frame. txd returns high on the next edge.
- Register map (all accesses require iocs=1):
  - 00 write: push databus[DATA_W-1:0] to TX FIFO. Dropped if the FIFO is full.
  - 00 read: drive RX head (zero-extended) combinationally and pop at the clock edge. Empty: drive 8'h00, no pop.
  - 01 read: status = {2'b0, tx_idle, perr, ferr, ovr, tbr, rda}. Clears ovr, ferr and perr at that edge; a flag set in the same cycle wins.
  - 01 write: no effect.
  - 10 write: divisor[7:0]. 11 write: divisor[15:8]. Either write reloads the baud counter with the new divisor.
  - 10/11 read: return the divisor bytes.
- Baud generator:
  - 16-bit down-counter. At 0 it emits a one-cycle tick and reloads the divisor, so the tick period is divisor+1 clocks.
  - Divisor 0 gives a tick every clock. One bit time = 16 ticks.
- TX FSM: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - Leaves IDLE on a tick when the FIFO is not empty, popping the head.
  - Start bit 0, then DATA_W bits LSB first, then one stop bit 1. Each bit is held 16 ticks.
  - From STOP with a non-empty FIFO, goes straight to START (back-to-back frames, no idle gap).
  - tx_idle=1 only in IDLE with the FIFO empty.
- RX:
  - rxd passes through a 2-flop synchroniser. Tick-sampled falling edge in IDLE -> START.
  - START: at tick 8, if the line is still 0 -> DATA, else back to IDLE (glitch rejected).
  - Sample each following bit every 16 ticks (mid-bit). Shift LSB first.
  - At the stop sample:
    - stop=0: ferr=1, byte discarded.
    - stop=1, FIFO full: ovr=1, new byte dropped, FIFO contents kept.
    - otherwise: push the byte.
  - Then return to IDLE.
- Simultaneous events:
  - Bus pop and RX push in the same cycle on a full FIFO: the push succeeds, no overrun.
  - Bus push and TX pop on a full TX FIFO: the push succeeds.
  - rda and tbr reflect FIFO state registered at each edge.

Optional Feature:
- SPART_PARITY_EN
- Defined:
  - Adds a parity bit after the data bits, enabled by status-write bit 0 via addr 01 (1 = even, reset 0 = disabled). When the bit is 0, frames are identical to the undefined build.
  - RX checks parity. On mismatch: perr=1 and the byte is still pushed.
- Undefined: no parity logic; perr reads 0; addr 01 writes are ignored.

Test Plan:
- Reset then read addr 01 -> 8'h22 (tx_idle=1, tbr=1). Read addr 10/11 -> 8'h45/8'h01.
- Divisor 16'h0003, write 8'h55 to addr 00 -> txd low for 64 clks, then bits 1,0,1,0,1,0,1,0 at 64 clks each, stop high 64 clks. tx_idle returns to 1.
- Loop txd to rxd, divisor 3, write 8'hA5, 8'h3C -> back-to-back frames. rda=1 after the first frame. Reads return 8'hA5 then 8'h3C. Third read returns 8'h00, rda=0.
- Loopback, RX_DEPTH=4, send 5 bytes without reading -> the first 4 are read back intact and ovr=1. A second status read shows ovr=0.
- Drive rxd low for a full frame with stop=0 -> ferr=1, no push (rda stays 0). A 2-tick low glitch on rxd -> no frame, no flags.
- SPART_PARITY_EN, even parity, inject 8'h07 with parity bit 0 -> perr=1, byte 8'h07 readable.
